uart_pin_mirror_rx: RTL and testbench
=====================================

# uart_pin_mirror_rx

Receive-side stage of the pin-state transfer link. Deserialises the 115200-baud 8N1 stream sent by the pin-sampling transmitter, which sends one ASCII '0' (0x30) or '1' (0x31) every 0.5 s. It mirrors the remote pin level onto a local output. A link watchdog flags loss of traffic, and single-cycle status pulses report accepted and rejected bytes.

## Interface
- BAUD_DIV, 104, clock cycles per UART bit (12 MHz / 115200).
- TIMEOUT, 18_000_000, cycles without an accepted byte before LINK_OK drops (1.5 s, three missed frames).
- CLK  input  1  12 MHz system clock; all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- RX  input  1  UART serial input, idle high, asynchronous to CLK.
- PIN_OUT  output  1  mirrored remote pin level.
- LINK_OK  output  1  high while the last accepted byte is younger than TIMEOUT cycles.
- RX_VALID  output  1  one-cycle pulse per accepted byte (0x30/0x31).
- RX_ERR  output  1  one-cycle pulse per framing error or unrecognised byte.

## Operation
- RX passes through a 2-FF synchroniser (both FFs reset to 1); all decoding uses the second-stage output `rxs`.
- Bit counter: log2(BAUD_DIV) bits minimum, 8 bits at default. Bit index: 3 bits. Shift register: 8 bits, LSB first; each sample shifts right and inserts at bit 7.
- FSM states and transitions:
  - IDLE: counter held at 0. `rxs`==0 -> START.
  - START: count to BAUD_DIV/2-1 (51). At that count, sample `rxs`. If it is 1, the low pulse was a glitch -> IDLE with no pulse. If it is 0 -> DATA, with counter 0 and index 0.
  - DATA: at count BAUD_DIV-1, sample into the shift register. On index 7 -> STOP; otherwise increment the index.
  - STOP: at count BAUD_DIV-1, sample `rxs`. If it is 1, evaluate the byte -> IDLE. If it is 0, the frame has a framing error: pulse RX_ERR -> WAIT_HIGH.
  - WAIT_HIGH: remain until `rxs`==1 -> IDLE. This prevents a held-low line or break from being decoded as endless 0x00 frames.
  - Any undefined state encoding -> IDLE.
- Byte evaluation, applied in the cycle after the stop sample:
  - 0x31: PIN_OUT<=1, RX_VALID pulse, watchdog cleared.
  - 0x30: PIN_OUT<=0, RX_VALID pulse, watchdog cleared.
  - Any other value: RX_ERR pulse; PIN_OUT and watchdog untouched.
- Watchdog: a 25-bit counter increments every cycle and saturates at TIMEOUT. It is set to 0 on an accepted byte. LINK_OK = (counter != TIMEOUT), registered.
- PIN_OUT holds its last value on timeout. The consumer uses LINK_OK to qualify it.

## Timing
- Reset values:
  - PIN_OUT=0, LINK_OK=0, RX_VALID=0, RX_ERR=0.
  - State IDLE; counters 0; shift register 0.
  - Watchdog counter = TIMEOUT, so the link reads down until the first valid byte.
- Reset asserted mid-frame aborts the frame immediately. No pulse is produced and the outputs take their reset values. After release, decoding restarts at the next falling edge seen in IDLE.
- Latency: the synchroniser adds 2 cycles. Let cycle 0 be the first cycle `rxs`==0.
  - Start-bit check at cycle 51.
  - Data bit n sampled at cycle 51+104·(n+1).
  - Stop sample at cycle 987.
  - PIN_OUT, RX_VALID, RX_ERR and the watchdog clear all update at cycle 988.
  - LINK_OK rises at cycle 989.
- RX_VALID and RX_ERR are never high in the same cycle. Each pulse is exactly 1 cycle wide.
- A falling edge that arrives during the single IDLE cycle after the stop sample is captured normally; back-to-back frames with one stop bit decode without loss.
- Watchdog saturation: LINK_OK falls TIMEOUT+1 cycles after the cycle in which the counter cleared. If a byte is accepted in the same cycle the counter reaches TIMEOUT, the clear wins and LINK_OK stays high.
- Baud tolerance: mid-bit sampling tolerates ±3% transmitter rate error.

## Test plan
- Reset, then send 0x31 at 104 cycles/bit:
  - PIN_OUT 0->1 at cycle 990 after the RX falling edge (2-cycle synchroniser plus 988).
  - RX_VALID high 1 cycle.
  - LINK_OK 0->1 one cycle later.
- Send 0x31, then 0x30 back-to-back with one stop bit:
  - Two RX_VALID pulses.
  - PIN_OUT ends at 0.
  - RX_ERR never asserted.
- Send 0x41 after PIN_OUT=1:
  - RX_ERR pulses once.
  - PIN_OUT stays 1 and RX_VALID stays 0.
  - Watchdog is not cleared: with TIMEOUT=5000, LINK_OK falls 5001 cycles after the previous valid byte.
- Framing and glitch:
  - 0x30 with stop bit held low for 2000 cycles: one RX_ERR pulse, PIN_OUT unchanged, no further frames until RX returns high.
  - 20-cycle low glitch on RX: no pulses, FSM back in IDLE.
- Watchdog with TIMEOUT=5000:
  - Valid byte, then idle: LINK_OK falls exactly 5001 cycles after the RX_VALID cycle.
  - A new 0x31 restores LINK_OK.
  - Transmitter run at 101 and 107 cycles/bit: all bytes accepted.
- Reset mid-frame: assert RST_N low at data bit 4 of a 0x31 frame.
  - All outputs reset immediately and no pulse is produced.
  - A following 0x31 frame is decoded normally.

Source files
------------

// File: rtl/uart_pin_mirror_rx_if.sv
// Signal bundle between the pin-mirror receiver and its environment.
// master drives the serial line; slave is the receiver itself.
interface uart_pin_mirror_rx_if;
    logic RX;
    logic PIN_OUT;
    logic LINK_OK;
    logic RX_VALID;
    logic RX_ERR;

    modport master (
        output RX,
        input  PIN_OUT,
        input  LINK_OK,
        input  RX_VALID,
        input  RX_ERR
    );

    modport slave (
        input  RX,
        output PIN_OUT,
        output LINK_OK,
        output RX_VALID,
        output RX_ERR
    );
endinterface

// File: rtl/uart_pin_mirror_rx.sv
// 8N1 receiver that mirrors a remote pin sent as ASCII '0'/'1', with a
// link watchdog and one-cycle accept/reject status pulses.
module uart_pin_mirror_rx #(
    parameter int unsigned BAUD_DIV = 104,
    parameter int unsigned TIMEOUT  = 18_000_000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    uart_pin_mirror_rx_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV) + 1;
    localparam int unsigned WD_W  = 25;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rxs;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_pin;
    logic             r_valid;
    logic             r_err;

    logic [WD_W-1:0]  r_wd;
    logic             r_link;
    logic             w_accept;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.RX;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // Good stop bit on a recognised byte: mirrors the FSM's accept path.
    assign w_accept = (r_state == S_STOP) && (r_cnt == CNT_FULL) && w_rxs &&
                      ((r_shift == 8'h30) || (r_shift == 8'h31));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_pin   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) begin
                        // The detecting cycle is count 0, so START begins at 1.
                        r_state <= S_START;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                            if (r_shift == 8'h31) begin
                                r_pin   <= 1'b1;
                                r_valid <= 1'b1;
                            end else if (r_shift == 8'h30) begin
                                r_pin   <= 1'b0;
                                r_valid <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_state <= S_WAIT_HIGH;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    r_cnt <= '0;
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Watchdog starts saturated so the link reads down until the first byte.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wd   <= WD_MAX;
            r_link <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wd <= '0;
            end else if (r_wd != WD_MAX) begin
                r_wd <= r_wd + WD_W'(1);
            end
            r_link <= (r_wd != WD_MAX);
        end
    end

    assign bus.PIN_OUT  = r_pin;
    assign bus.LINK_OK  = r_link;
    assign bus.RX_VALID = r_valid;
    assign bus.RX_ERR   = r_err;

endmodule

// File: tb/tb_uart_pin_mirror_rx.sv
// Directed bench for uart_pin_mirror_rx: frame-level model of the expected
// outputs checked every cycle, plus literal latency/count expectations.
module tb_uart_pin_mirror_rx;

    localparam int TO  = 5000;
    localparam int LAT = 990;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_pin_mirror_rx_if bus ();

    uart_pin_mirror_rx #(
        .BAUD_DIV (104),
        .TIMEOUT  (TO)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         t;
        logic [7:0] b;
        bit         stop_ok;
    } ev_t;

    ev_t  evs[$];
    int   ev_rd = 0;

    int   checks = 0;
    int   failures = 0;

    logic m_pin = 1'b0;
    bit   m_have = 1'b0;
    int   m_last = 0;

    int   n_valid = 0;
    int   n_err = 0;
    int   first_valid_t = -1;
    int   last_valid_t = -1;
    int   pin_rise_t = -1;
    int   link_rise_t = -1;
    int   link_fall_t = -1;
    logic prev_pin = 1'b0;
    logic prev_link = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.PIN_OUT, bus.LINK_OK, bus.RX_VALID, bus.RX_ERR});
    endfunction

    // Expected outputs follow from the frames sent: each frame resolves
    // LAT cycles after its start edge, LINK_OK holds for TO cycles after.
    task automatic model_step();
        logic       ev_v;
        logic       ev_e;
        logic       exp_link;
        bit         acc;
        logic [7:0] b;
        logic [3:0] got;
        logic [3:0] exp;
        if (!rst_n) begin
            m_pin     = 1'b0;
            m_have    = 1'b0;
            prev_pin  = 1'b0;
            prev_link = 1'b0;
            ev_rd     = evs.size();
        end else begin
            ev_v = 1'b0;
            ev_e = 1'b0;
            acc  = 1'b0;
            exp_link = m_have && ((cyc - m_last) >= 1) && ((cyc - m_last) <= TO);
            if (ev_rd < evs.size() && evs[ev_rd].t == cyc) begin
                b = evs[ev_rd].b;
                if (evs[ev_rd].stop_ok && (b == 8'h30 || b == 8'h31)) begin
                    ev_v  = 1'b1;
                    m_pin = b[0];
                    acc   = 1'b1;
                end else begin
                    ev_e = 1'b1;
                end
                ev_rd++;
            end
            exp = {m_pin, exp_link, ev_v, ev_e};
            got = {bus.PIN_OUT, bus.LINK_OK, bus.RX_VALID, bus.RX_ERR};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL cycle_cmp cyc=%0d pin/link/valid/err actual=%b required=%b",
                         cyc, got, exp);
            end
            if (acc) begin
                m_have = 1'b1;
                m_last = cyc;
            end
            if (bus.RX_VALID) begin
                n_valid++;
                last_valid_t = cyc;
                if (first_valid_t < 0) first_valid_t = cyc;
            end
            if (bus.RX_ERR) n_err++;
            if (bus.PIN_OUT && !prev_pin) pin_rise_t = cyc;
            if (bus.LINK_OK && !prev_link) link_rise_t = cyc;
            if (!bus.LINK_OK && prev_link) link_fall_t = cyc;
            prev_pin  = bus.PIN_OUT;
            prev_link = bus.LINK_OK;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // stop_low == 0 sends a good stop bit; otherwise the line is held low.
    task automatic send(input logic [7:0] b, input int baud, input int stop_low);
        ev_t e;
        e.t = cyc + LAT;
        e.b = b;
        e.stop_ok = (stop_low == 0);
        evs.push_back(e);
        bus.RX = 1'b0;
        repeat (baud) tick();
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            repeat (baud) tick();
        end
        if (stop_low != 0) begin
            bus.RX = 1'b0;
            repeat (stop_low) tick();
        end
        bus.RX = 1'b1;
        repeat (baud) tick();
    endtask

    initial begin
        int c0;
        int nv;
        int ne;
        logic [7:0] mb;

        bus.RX = 1'b1;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        idle(5);
        chk("reset_outs", outs(), 0);
        rst_n = 1'b1;
        idle(3);
        chk("post_reset_outs", outs(), 0);

        c0 = cyc;
        nv = n_valid;
        send(8'h31, 104, 0);
        idle(5);
        chk("first_valid_latency", first_valid_t - c0, 990);
        chk("first_pin_rise", pin_rise_t - c0, 990);
        chk("first_link_rise", link_rise_t - c0, 991);
        chk("first_valid_count", n_valid - nv, 1);

        nv = n_valid;
        ne = n_err;
        send(8'h31, 104, 0);
        send(8'h30, 104, 0);
        idle(5);
        chk("b2b_valid_count", n_valid - nv, 2);
        chk("b2b_err_count", n_err - ne, 0);
        chk("b2b_pin", int'(bus.PIN_OUT), 0);

        nv = n_valid;
        ne = n_err;
        send(8'h31, 104, 0);
        send(8'h41, 104, 0);
        idle(5200);
        chk("bad_byte_err_count", n_err - ne, 1);
        chk("bad_byte_valid_count", n_valid - nv, 1);
        chk("bad_byte_pin", int'(bus.PIN_OUT), 1);
        chk("watchdog_fall_delay", link_fall_t - last_valid_t, 5001);
        chk("watchdog_link_low", int'(bus.LINK_OK), 0);

        send(8'h31, 104, 0);
        idle(5);
        chk("link_restored", int'(bus.LINK_OK), 1);

        nv = n_valid;
        ne = n_err;
        send(8'h30, 101, 0);
        send(8'h31, 101, 0);
        send(8'h30, 107, 0);
        send(8'h31, 107, 0);
        idle(5);
        chk("baud_tol_valid_count", n_valid - nv, 4);
        chk("baud_tol_err_count", n_err - ne, 0);

        nv = n_valid;
        ne = n_err;
        send(8'h30, 104, 2000);
        idle(10);
        chk("framing_err_count", n_err - ne, 1);
        chk("framing_valid_count", n_valid - nv, 0);
        chk("framing_pin", int'(bus.PIN_OUT), 1);

        nv = n_valid;
        ne = n_err;
        bus.RX = 1'b0;
        idle(20);
        bus.RX = 1'b1;
        idle(1200);
        chk("glitch_pulses", (n_valid - nv) + (n_err - ne), 0);
        send(8'h30, 104, 0);
        idle(5);
        chk("post_glitch_valid", n_valid - nv, 1);
        chk("post_glitch_pin", int'(bus.PIN_OUT), 0);

        send(8'h31, 104, 0);
        idle(5);
        chk("pre_reset_pin", int'(bus.PIN_OUT), 1);
        mb = 8'h31;
        bus.RX = 1'b0;
        idle(104);
        for (int i = 0; i < 4; i++) begin
            bus.RX = mb[i];
            idle(104);
        end
        bus.RX = mb[4];
        idle(10);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outs", outs(), 0);
        bus.RX = 1'b1;
        nv = n_valid;
        ne = n_err;
        idle(20);
        rst_n = 1'b1;
        idle(1100);
        chk("midframe_no_pulse", (n_valid - nv) + (n_err - ne), 0);
        send(8'h31, 104, 0);
        idle(5);
        chk("after_reset_valid", n_valid - nv, 1);
        chk("after_reset_pin", int'(bus.PIN_OUT), 1);
        chk("after_reset_link", int'(bus.LINK_OK), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
